// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULTU / DIVU controller built around the
// ALU's shared 32-bit adder. Keeps the HI/LO result registers and reports
// its progress to the pipeline stall logic through busy / done.
//
// Handshake: start is sampled only in IDLE. An accepted start moves the
// block to MULT or DIV, where busy is 1 for exactly ITERATIONS cycles. It
// then spends one cycle in DONE, where done is 1. A divide by zero goes
// straight to DONE. A start seen outside IDLE is dropped and never queued.
// busy and done are pure state decodes, so start has no combinational
// path to either of them.
module muldiv_sequencer #(
  parameter logic [31:0] DIV0_LO    = 32'hFFFFFFFF,
  parameter int          ITERATIONS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_result,
  input  logic        add_cout,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  localparam logic [5:0] LAST_ITER = 6'(ITERATIONS - 1);

  // state is kept as a named signal so that checkers can bind to it
  state_t      state;
  state_t      state_next;
  logic [5:0]  cnt;
  logic [31:0] m;
  logic [31:0] r_prime;
  logic        ovf;
  logic        last_iter;
  logic        div_zero_req;

  // The partial remainder is shifted left by one. The bit that falls off
  // the top of hi is kept as ovf, so the remainder is really 33 bits wide.
  assign r_prime      = {hi[30:0], lo[31]};
  assign ovf          = hi[31];
  assign last_iter    = (cnt == LAST_ITER);
  assign div_zero_req = op_div && (op_b == 32'd0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: accept start only in IDLE; leave after the last iteration
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (div_zero_req) state_next = DONE;
          else if (op_div)  state_next = DIV;
          else              state_next = MULT;
        end
      end
      MULT:    if (last_iter) state_next = DONE;
      DIV:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: status flags and adder drive, all taken from the state
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    add_a   = 32'd0;
    add_b   = 32'd0;
    add_cin = 1'b0;
    case (state)
      MULT: begin
        busy  = 1'b1;
        add_a = hi;
        add_b = m;
      end
      DIV: begin
        busy    = 1'b1;
        add_a   = r_prime;
        add_b   = m;
        add_cin = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture on accept, then one shift/add step per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      hi          <= 32'd0;
      lo          <= 32'd0;
      m           <= 32'd0;
      cnt         <= 6'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m   <= op_b;
            cnt <= 6'd0;
            if (div_zero_req) begin
              hi          <= op_a;
              lo          <= DIV0_LO;
              div_by_zero <= 1'b1;
            end else begin
              hi          <= 32'd0;
              lo          <= op_a;
              div_by_zero <= 1'b0;
            end
          end
        end
        MULT: begin
          cnt <= cnt + 6'd1;
          // Shift the 65-bit {carry, partial product, multiplier} right by one
          if (lo[0]) begin
            hi <= {add_cout, add_result[31:1]};
            lo <= {add_result[0], lo[31:1]};
          end else begin
            hi <= {1'b0, hi[31:1]};
            lo <= {hi[0], lo[31:1]};
          end
        end
        DIV: begin
          cnt <= cnt + 6'd1;
          // Restoring step: subtract only when the shifted remainder is >= divisor
          if (ovf || add_cout) begin
            hi <= add_result;
            lo <= {lo[30:0], 1'b1};
          end else begin
            hi <= r_prime;
            lo <= {lo[30:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer. It models the
// shared ALU adder and computes reference results with native arithmetic.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_result;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors     = 0;
  int miscompares = 0;

  // Each entry is {div_by_zero, hi, lo}
  logic [64:0] exp_q[$];

  muldiv_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_div      (op_div),
    .op_a        (op_a),
    .op_b        (op_b),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_cin     (add_cin),
    .add_result  (add_result),
    .add_cout    (add_cout),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  // Clock
  always #5 clk = ~clk;

  // Shared ALU adder: when c_in is set it inverts b and adds 1
  logic [32:0] sum;
  assign sum        = {1'b0, add_a} + {1'b0, (add_cin ? ~add_b : add_b)} + {32'd0, add_cin};
  assign add_result = sum[31:0];
  assign add_cout   = sum[32];

  function automatic logic [64:0] model(input logic d, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (!d) begin
      p = {32'd0, a} * {32'd0, b};
      return {1'b0, p};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
    return {1'b0, a % b, a / b};
  endfunction

  // Driver: present one start pulse in IDLE and queue the expected result
  task automatic issue(input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    op_div = d;
    op_a   = a;
    op_b   = b;
    exp_q.push_back(model(d, a, b));
    @(posedge clk);
    #1;
    start  = 1'b0;
    op_div = 1'($urandom_range(0, 1));
    op_a   = $urandom;
    op_b   = $urandom;
  endtask

  // Monitor: watch until done, checking timing and adder drive, then score.
  // When inject is non-zero, a spurious start is driven during that busy cycle.
  task automatic wait_done(input string name, input logic d, input int lat, input int inject);
    int          cyc     = 0;
    int          nbusy   = 0;
    bit          seen    = 0;
    bit          overlap = 0;
    bit          bad_drv = 0;
    logic [64:0] exp;
    logic [64:0] got;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy && done) overlap = 1;
      if (busy) begin
        nbusy++;
        if (add_cin !== d) bad_drv = 1;
      end
      if (done) begin
        seen = 1;
        got  = {div_by_zero, hi, lo};
        if (add_a !== 32'd0 || add_b !== 32'd0 || add_cin !== 1'b0) bad_drv = 1;
      end
      if (inject != 0 && cyc == inject) begin
        start  = 1'b1;
        op_div = ~d;
        op_a   = 32'h0000_1234;
        op_b   = 32'd0;
      end else if (inject != 0 && cyc == inject + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 65'd0;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s timeout: no done after %0d cycles, required at cycle %0d", name, cyc, lat);
      return;
    end
    if (cyc !== lat) begin
      miscompares++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, cyc, lat);
    end
    vectors++;
    if (nbusy !== lat - 1) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, nbusy, lat - 1);
    end
    vectors++;
    if (overlap !== 1'b0 || bad_drv !== 1'b0) begin
      miscompares++;
      $display("FAIL %s handshake_drive: overlap=%0d bad_adder_drive=%0d want 0 0", name, overlap, bad_drv);
    end
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s result: got dbz=%0d hi=%h lo=%h want dbz=%0d hi=%h lo=%h",
               name, got[64], got[63:32], got[31:0], exp[64], exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    op_div = 1'b0;
    op_a   = 32'd0;
    op_b   = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got busy=%0d done=%0d dbz=%0d want 0 0 0", busy, done, div_by_zero);
    end
    vectors++;
    if ({hi, lo} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_hilo: got hi=%h lo=%h want 0 0", hi, lo);
    end
    vectors++;
    if ({add_a, add_b, add_cin} !== 65'd0) begin
      miscompares++;
      $display("FAIL reset_adder: got a=%h b=%h cin=%0d want 0 0 0", add_a, add_b, add_cin);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%0d done=%0d want 0 0", busy, done);
    end
  endtask

  task automatic test_multu();
    logic [31:0] a;
    logic [31:0] b;
    issue(1'b0, 32'd7, 32'd6);
    wait_done("mul_7x6", 1'b0, 33, 0);
    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("mul_max", 1'b0, 33, 0);
    issue(1'b0, 32'h8000_0001, 32'd0);
    wait_done("mul_zero", 1'b0, 33, 0);
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      issue(1'b0, a, b);
      wait_done("mul_rand", 1'b0, 33, 0);
    end
  endtask

  task automatic test_divu();
    logic [31:0] a;
    logic [31:0] b;
    issue(1'b1, 32'd100, 32'd7);
    wait_done("div_100_7", 1'b1, 33, 0);
    issue(1'b1, 32'hFFFFFFFF, 32'd1);
    wait_done("div_max_1", 1'b1, 33, 0);
    issue(1'b1, 32'hFFFFFFFF, 32'h8000_0001);
    wait_done("div_big_divisor", 1'b1, 33, 0);
    issue(1'b1, 32'd3, 32'd9);
    wait_done("div_small_dividend", 1'b1, 33, 0);
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : ($urandom | 32'h1);
      issue(1'b1, a, b);
      wait_done("div_rand", 1'b1, 33, 0);
    end
  endtask

  task automatic test_div_by_zero();
    issue(1'b1, 32'd5, 32'd0);
    wait_done("div_by_zero", 1'b1, 1, 0);
    repeat (3) @(negedge clk);
    vectors++;
    if ({div_by_zero, hi, lo} !== {1'b1, 32'd5, 32'hFFFFFFFF}) begin
      miscompares++;
      $display("FAIL div0_hold: got dbz=%0d hi=%h lo=%h want 1 00000005 ffffffff", div_by_zero, hi, lo);
    end
    issue(1'b0, 32'd3, 32'd4);
    wait_done("mul_after_div0", 1'b0, 33, 0);
  endtask

  task automatic test_start_ignored();
    issue(1'b0, 32'd1000, 32'd77);
    wait_done("mul_start_during_busy", 1'b0, 33, 11);
    issue(1'b1, 32'd5000, 32'd13);
    wait_done("div_start_during_busy", 1'b1, 33, 11);
  endtask

  task automatic test_reset_mid_op();
    issue(1'b0, 32'd123, 32'd456);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
    vectors++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_mid_op: got busy=%0d done=%0d hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_after_mid_reset: got busy=%0d done=%0d want 0 0", busy, done);
    end
    issue(1'b0, 32'd123, 32'd456);
    wait_done("mul_after_reset", 1'b0, 33, 0);
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 32'd1_000_000, 32'd999);
    wait_done("b2b_div", 1'b1, 33, 0);
    issue(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    wait_done("b2b_mul", 1'b0, 33, 0);
    issue(1'b1, 32'h1234_5678, 32'd0);
    wait_done("b2b_div0", 1'b1, 1, 0);
    issue(1'b1, 32'h1234_5678, 32'h0000_0100);
    wait_done("b2b_div_after_div0", 1'b1, 33, 0);
  endtask

  initial begin
    test_reset();
    test_multu();
    test_divu();
    test_div_by_zero();
    test_start_ignored();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
